seq_shift_add_multiplier: RTL

//  Parametrised, clocked shift-add multiplier producing a 2*WIDTH-bit product.

---
 rtl/seq_shift_add_multiplier_pkg.sv | 21 ++
 rtl/seq_shift_add_multiplier_addsub.sv | 28 ++
 rtl/seq_shift_add_multiplier.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the ceiling-log2 helper used to size the step counter.
package seq_shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bits needed to count 0..v-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_addsub.sv
// WIDTH-bit ripple-carry adder/subtractor built from full-adder cells.
// sub_i=1 computes a_i - b_i (invert b, carry-in 1); carry-out is discarded.
module addsub_nbit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] b_x;

    // Ripple chain of full-adder equations, LSB first.
    always_comb begin
        carry    = '0;
        b_x      = '0;
        sum_o    = '0;
        carry[0] = sub_i;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            b_x[i]       = b_i[i] ^ sub_i;
            sum_o[i]     = a_i[i] ^ b_x[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_x[i]) | (carry[i] & (a_i[i] ^ b_x[i]));
        end
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: one (WIDTH+1)-bit adder reused over WIDTH
// cycles, start/done handshake, run-time signed/unsigned operand mode.
// Signed operands are converted to magnitudes on accept and the product is
// negated on the way into p when the operand signs differ.
module seq_shift_add_multiplier
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int unsigned CNT_W = clog2(WIDTH);

    state_e               state_q;
    logic [WIDTH-1:0]     mr_q;
    logic [WIDTH-1:0]     qr_q;
    logic [WIDTH:0]       acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   p_q;

    logic                 sgn;
    logic                 neg_d;
    logic [WIDTH-1:0]     m_neg;
    logic [WIDTH-1:0]     q_neg;
    logic [WIDTH-1:0]     mr_d;
    logic [WIDTH-1:0]     qr_d;
    logic [WIDTH:0]       addend;
    logic [WIDTH:0]       acc_sum;
    logic [2*WIDTH:0]     pair_shift;
    logic [2*WIDTH-1:0]   pair_neg;
    logic [2*WIDTH-1:0]   p_d;

    addsub_nbit #(.WIDTH(WIDTH)) u_neg_m (
        .a_i   ('0),
        .b_i   (m),
        .sub_i (1'b1),
        .sum_o (m_neg)
    );

    addsub_nbit #(.WIDTH(WIDTH)) u_neg_q (
        .a_i   ('0),
        .b_i   (q),
        .sub_i (1'b1),
        .sum_o (q_neg)
    );

    addsub_nbit #(.WIDTH(WIDTH + 1)) u_acc (
        .a_i   (acc_q),
        .b_i   (addend),
        .sub_i (1'b0),
        .sum_o (acc_sum)
    );

    addsub_nbit #(.WIDTH(2 * WIDTH)) u_neg_p (
        .a_i   ('0),
        .b_i   (pair_shift[2*WIDTH-1:0]),
        .sub_i (1'b1),
        .sum_o (pair_neg)
    );

    // Operand magnitudes/sign on accept, and the per-cycle accumulate-and-shift.
    always_comb begin
        sgn        = signed_mode & (SIGNED_EN != 0);
        mr_d       = (sgn & m[WIDTH-1]) ? m_neg : m;
        qr_d       = (sgn & q[WIDTH-1]) ? q_neg : q;
        neg_d      = sgn & (m[WIDTH-1] ^ q[WIDTH-1]);
        addend     = qr_q[0] ? {1'b0, mr_q} : '0;
        pair_shift = {acc_sum, qr_q} >> 1;
        p_d        = neg_q ? pair_neg : pair_shift[2*WIDTH-1:0];
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mr_q    <= '0;
            qr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_CALC;
                        busy_q  <= 1'b1;
                        mr_q    <= mr_d;
                        qr_q    <= qr_d;
                        neg_q   <= neg_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_CALC: begin
                    acc_q <= pair_shift[2*WIDTH:WIDTH];
                    qr_q  <= pair_shift[WIDTH-1:0];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        p_q     <= p_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule
